pc_branch_unit: RTL



---
 rtl/defs_pkg.sv | 54 +++++
 rtl/ret_stack.sv | 69 ++++++
 rtl/pc_branch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/defs_pkg.sv
// Shared CPU types: ALU flag bundle, branch opcodes, condition codes
// and the condition evaluator used by the PC/branch block.
package defs_pkg;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_JMP  = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_op_t;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_CS = 4'd3,
    COND_CC = 4'd4,
    COND_MI = 4'd5,
    COND_PL = 4'd6,
    COND_VS = 4'd7,
    COND_VC = 4'd8,
    COND_GE = 4'd9,
    COND_LT = 4'd10
  } br_cond_t;

  // Undefined condition encodings evaluate false so they never redirect the PC.
  function automatic logic cond_eval(input br_cond_t cond, input alu_flags_t f);
    logic result;
    result = 1'b0;
    case (cond)
      COND_AL: result = 1'b1;
      COND_EQ: result = f.zero;
      COND_NE: result = !f.zero;
      COND_CS: result = f.carry;
      COND_CC: result = !f.carry;
      COND_MI: result = f.negative;
      COND_PL: result = !f.negative;
      COND_VS: result = f.overflow;
      COND_VC: result = !f.overflow;
      COND_GE: result = (f.negative == f.overflow);
      COND_LT: result = (f.negative != f.overflow);
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Small return-address LIFO. Entries live in flops so reset can clear them;
// push takes priority if the caller ever asserts push and pop together.
module ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]     sp,
  output logic                           full,
  output logic                           empty
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [SPW-1:0]   sp_reg;
  logic [SPW-1:0]   sp_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (sp_reg == SPW'(DEPTH));
  assign empty   = (sp_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !push && !empty;

  always_comb begin
    sp_next = sp_reg;
    if (do_push)
      sp_next = sp_reg + SPW'(1);
    else if (do_pop)
      sp_next = sp_reg - SPW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      sp_reg <= '0;
    else
      sp_reg <= sp_next;
  end

  // Each entry is written only when the stack pointer addresses it.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst)
          mem_reg[gi] <= '0;
        else if (do_push && (sp_reg == SPW'(gi)))
          mem_reg[gi] <= push_data;
      end
    end
  endgenerate

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_reg == SPW'(i + 1))
        top = mem_reg[i];
    end
  end

  assign sp = sp_reg;

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with flag register, condition evaluation and
// jump/call/return resolution; one PC update per asserted step.
module pc_branch_unit
  import defs_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  alu_flags_t                  flags_in,
  input  logic                        flags_we,
  input  logic                        step,
  input  br_op_t                      br_op,
  input  br_cond_t                    br_cond,
  input  logic [WIDTH-1:0]            target,
  output logic [WIDTH-1:0]            pc,
  output alu_flags_t                  flags_q,
  output logic                        taken,
  output logic [$clog2(DEPTH+1)-1:0]  sp,
  output logic                        stack_err
);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  alu_flags_t       flags_reg;
  alu_flags_t       flags_next;
  logic             taken_reg;
  logic             taken_next;
  logic             err_reg;
  logic             err_next;
  logic             cond_ok;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full;
  logic             stk_empty;

  // Conditions always look at the registered flags, so a same-cycle
  // flags_we only affects the following instruction.
  assign cond_ok = cond_eval(br_cond, flags_reg);
  assign pc_inc  = pc_reg + WIDTH'(1);

  always_comb begin
    pc_next    = pc_reg;
    taken_next = 1'b0;
    err_next   = err_reg;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    flags_next = flags_we ? flags_in : flags_reg;
    if (step) begin
      pc_next = pc_inc;
      case (br_op)
        BR_JMP: begin
          if (cond_ok) begin
            pc_next    = target;
            taken_next = 1'b1;
          end
        end
        BR_CALL: begin
          if (cond_ok) begin
            if (!stk_full) begin
              stk_push   = 1'b1;
              pc_next    = target;
              taken_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        BR_RET: begin
          if (cond_ok) begin
            if (!stk_empty) begin
              stk_pop    = 1'b1;
              pc_next    = stk_top;
              taken_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      flags_reg <= '0;
      taken_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      flags_reg <= flags_next;
      taken_reg <= taken_next;
      err_reg   <= err_next;
    end
  end

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .sp        (sp),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign pc        = pc_reg;
  assign flags_q   = flags_reg;
  assign taken     = taken_reg;
  assign stack_err = err_reg;

endmodule
